// File: rtl/hazard_stall_controller_if.sv
// Hazard-information and pipeline-control bundle between the pipeline
// datapath (slave side) and the stall/flush sequencer (master side).
interface hazard_stall_controller_if #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] src1_ID_RF;
    logic [REG_W-1:0] src2_ID_RF;
    logic             use1_ID_RF;
    logic             use2_ID_RF;
    logic [REG_W-1:0] dest_RF_EX;
    logic [REG_W-1:0] dest_EX_M;
    logic             wb_RF_EX;
    logic             wb_EX_M;
    logic             mem_rd_RF_EX;
    logic             mem_rd_EX_M;
    logic             mul_RF_EX;
    logic             branch_taken_EX;
    logic             mem_busy;

    logic             pc_en;
    logic             en_IF_ID;
    logic             en_ID_RF;
    logic             en_RF_EX;
    logic             en_EX_M;
    logic             en_M_WB;
    logic             flush_IF_ID;
    logic             flush_ID_RF;
    logic             flush_RF_EX;
    logic             bubble_EX_M;
    logic             mul_busy;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        input  src1_ID_RF, src2_ID_RF, use1_ID_RF, use2_ID_RF,
        input  dest_RF_EX, dest_EX_M, wb_RF_EX, wb_EX_M,
        input  mem_rd_RF_EX, mem_rd_EX_M, mul_RF_EX, branch_taken_EX, mem_busy,
        output pc_en, en_IF_ID, en_ID_RF, en_RF_EX, en_EX_M, en_M_WB,
        output flush_IF_ID, flush_ID_RF, flush_RF_EX, bubble_EX_M,
        output mul_busy, stall_cycles
    );

    modport slave (
        output src1_ID_RF, src2_ID_RF, use1_ID_RF, use2_ID_RF,
        output dest_RF_EX, dest_EX_M, wb_RF_EX, wb_EX_M,
        output mem_rd_RF_EX, mem_rd_EX_M, mul_RF_EX, branch_taken_EX, mem_busy,
        input  pc_en, en_IF_ID, en_ID_RF, en_RF_EX, en_EX_M, en_M_WB,
        input  flush_IF_ID, flush_ID_RF, flush_RF_EX, bubble_EX_M,
        input  mul_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer for the 6-stage pipe: load-use bubbles, multi-cycle
// multiply occupancy of EX, taken-branch flushes and memory-wait freezes.
module hazard_stall_controller #(
    parameter int REG_W   = 3,
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    hazard_stall_controller_if.master bus
);
    typedef enum logic {RUN, MUL_BUSY} state_t;

    localparam int MC_W    = (MUL_LAT > 3) ? $clog2(MUL_LAT - 1) : 1;
    localparam int MC_INIT = (MUL_LAT >= 2) ? (MUL_LAT - 2) : 0;
    localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MC_INIT);
    localparam bit MUL_STALLS = (MUL_LAT >= 2);

    state_t           state_q, state_d;
    logic [MC_W-1:0]  mcnt_q, mcnt_d;
    logic [CNT_W-1:0] cnt_q;

    logic [REG_W-1:0] s1, s2, d_ex, d_m;
    logic             ld_ex, ld_m, load_use, mul_start;

    logic pc_en, en_if_id, en_id_rf, en_rf_ex, en_ex_m, en_m_wb;
    logic fl_if_id, fl_id_rf, fl_rf_ex, bub_ex_m;

    assign s1    = bus.src1_ID_RF;
    assign s2    = bus.src2_ID_RF;
    assign d_ex  = bus.dest_RF_EX;
    assign d_m   = bus.dest_EX_M;
    assign ld_ex = bus.wb_RF_EX & bus.mem_rd_RF_EX;
    assign ld_m  = bus.wb_EX_M & bus.mem_rd_EX_M;

    // Register 0 is deliberately not special-cased.
    assign load_use =
        (bus.use1_ID_RF & ((ld_ex & (s1 == d_ex)) | (ld_m & (s1 == d_m)))) |
        (bus.use2_ID_RF & ((ld_ex & (s2 == d_ex)) | (ld_m & (s2 == d_m))));

    assign mul_start = (state_q == RUN) & bus.mul_RF_EX & MUL_STALLS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            mcnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
            if (!pc_en && (cnt_q != '1))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcnt_d   = mcnt_q;
        pc_en    = 1'b1;
        en_if_id = 1'b1;
        en_id_rf = 1'b1;
        en_rf_ex = 1'b1;
        en_ex_m  = 1'b1;
        en_m_wb  = 1'b1;
        fl_if_id = 1'b0;
        fl_id_rf = 1'b0;
        fl_rf_ex = 1'b0;
        bub_ex_m = 1'b0;

        if (rst) begin
            pc_en    = 1'b0;
            en_if_id = 1'b0;
            en_id_rf = 1'b0;
            en_rf_ex = 1'b0;
            en_ex_m  = 1'b0;
            en_m_wb  = 1'b0;
            fl_if_id = 1'b1;
            fl_id_rf = 1'b1;
            fl_rf_ex = 1'b1;
            bub_ex_m = 1'b1;
        end else if (bus.mem_busy) begin
            pc_en    = 1'b0;
            en_if_id = 1'b0;
            en_id_rf = 1'b0;
            en_rf_ex = 1'b0;
            en_ex_m  = 1'b0;
            en_m_wb  = 1'b0;
        end else if (state_q == MUL_BUSY) begin
            if (mcnt_q != '0) begin
                pc_en    = 1'b0;
                en_if_id = 1'b0;
                en_id_rf = 1'b0;
                en_rf_ex = 1'b0;
                bub_ex_m = 1'b1;
                mcnt_d   = mcnt_q - 1'b1;
            end else begin
                // Release: the product is captured into EX_M this cycle.
                state_d = RUN;
                if (load_use) begin
                    pc_en    = 1'b0;
                    en_if_id = 1'b0;
                    en_id_rf = 1'b0;
                    fl_rf_ex = 1'b1;
                end
            end
        end else if (mul_start) begin
            pc_en    = 1'b0;
            en_if_id = 1'b0;
            en_id_rf = 1'b0;
            en_rf_ex = 1'b0;
            bub_ex_m = 1'b1;
            mcnt_d   = MC_LOAD;
            state_d  = MUL_BUSY;
        end else if (bus.branch_taken_EX) begin
            fl_if_id = 1'b1;
            fl_id_rf = 1'b1;
            fl_rf_ex = 1'b1;
        end else if (load_use) begin
            pc_en    = 1'b0;
            en_if_id = 1'b0;
            en_id_rf = 1'b0;
            fl_rf_ex = 1'b1;
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.en_IF_ID     = en_if_id;
    assign bus.en_ID_RF     = en_id_rf;
    assign bus.en_RF_EX     = en_rf_ex;
    assign bus.en_EX_M      = en_ex_m;
    assign bus.en_M_WB      = en_m_wb;
    assign bus.flush_IF_ID  = fl_if_id;
    assign bus.flush_ID_RF  = fl_id_rf;
    assign bus.flush_RF_EX  = fl_rf_ex;
    assign bus.bubble_EX_M  = bub_ex_m;
    assign bus.mul_busy     = (state_q == MUL_BUSY);
    assign bus.stall_cycles = cnt_q;
endmodule
